// File: rtl/tlk2711_pkg.sv
// Shared types and defaults for the TLK2711 TX test-pattern frame scheduler.
package tlk2711_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam logic [2:0]  MODE_LONG    = 3'd3;
    localparam logic [15:0] PAT_INIT_DEF = 16'h0001;
    localparam logic [15:0] PAT_STEP_DEF = 16'h0202;
    localparam int          LEN_NORM_DEF = 435;
    localparam int          LEN_LONG_DEF = 5377;

    // Wide enough for the long frame length.
    localparam int          LEN_W        = 13;

endpackage

// File: rtl/tlk2711_pat_gen.sv
// Pattern word generator: incrementing 16-bit pattern replicated on four lanes,
// closed by a zero filler word at index len-1.
module tlk2711_pat_gen
    import tlk2711_pkg::*;
#(
    parameter logic [15:0] PAT_INIT = PAT_INIT_DEF,
    parameter logic [15:0] PAT_STEP = PAT_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             restart,
    input  logic [LEN_W-1:0] len,
    output logic [63:0]      data,
    output logic             first,
    output logic             last
);

    logic [15:0]      pat;
    logic [LEN_W-1:0] idx;

    assign first = (idx == '0);
    assign last  = (idx == len - LEN_W'(1));
    assign data  = last ? 64'h0 : {4{pat}};

    // Issuing the filler word wraps straight back to the start of the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat <= PAT_INIT;
            idx <= '0;
        end else if (restart) begin
            pat <= PAT_INIT;
            idx <= '0;
        end else if (advance) begin
            if (last) begin
                pat <= PAT_INIT;
                idx <= '0;
            end else begin
                pat <= pat + PAT_STEP;
                idx <= idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/tlk2711_tx_frame_sched.sv
// TLK2711 TX frame scheduler: emits N frames (or continuous until stop) with an idle gap.
// Optional error injection on bit 0 of pattern words: define TLK2711_TX_SCHED_ERRINJ_EN.
module tlk2711_tx_frame_sched
    import tlk2711_pkg::*;
#(
    parameter int          LEN_NORM = LEN_NORM_DEF,
    parameter int          LEN_LONG = LEN_LONG_DEF,
    parameter logic [15:0] PAT_INIT = PAT_INIT_DEF,
    parameter logic [15:0] PAT_STEP = PAT_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_soft_rst,
    input  logic        i_tx_start,
    input  logic [2:0]  i_tx_mode,
    input  logic [15:0] i_frame_num,
    input  logic [15:0] i_gap_cycles,
    input  logic        i_tx_stop,
    input  logic        i_fifo_ready,
`ifdef TLK2711_TX_SCHED_ERRINJ_EN
    input  logic        i_err_inj,
    output logic [15:0] o_err_inj_cnt,
`endif
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic        o_done
);

    sched_state_t     state;
    logic             start_r;
    logic             start_p;
    logic [LEN_W-1:0] len_r;
    logic [15:0]      frame_num_r;
    logic [15:0]      gap_r;
    logic [15:0]      gap_cnt;
    logic             stop_pend;
    logic             issue;
    logic             stop_now;
    logic             target_met;
    logic [63:0]      pat_data;
    logic [63:0]      word;
    logic             pat_first;
    logic             pat_last;

    assign start_p    = i_tx_start & ~start_r;
    assign issue      = (state == DATA) && i_fifo_ready;
    assign stop_now   = stop_pend | i_tx_stop;
    assign target_met = (frame_num_r != 16'd0) && ((o_frame_cnt + 16'd1) == frame_num_r);

    tlk2711_pat_gen #(
        .PAT_INIT (PAT_INIT),
        .PAT_STEP (PAT_STEP)
    ) u_pat_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (issue),
        .restart (i_soft_rst || (state != DATA)),
        .len     (len_r),
        .data    (pat_data),
        .first   (pat_first),
        .last    (pat_last)
    );

`ifdef TLK2711_TX_SCHED_ERRINJ_EN
    logic inj_pend;
    logic inj_now;

    assign inj_now = issue && !pat_last && (inj_pend || i_err_inj);
    assign word    = pat_data ^ {63'd0, inj_now};

    // A pulse arriving while an earlier one is being consumed stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pend      <= 1'b0;
            o_err_inj_cnt <= 16'd0;
        end else if (i_soft_rst) begin
            inj_pend      <= 1'b0;
            o_err_inj_cnt <= 16'd0;
        end else if (inj_now) begin
            inj_pend      <= inj_pend & i_err_inj;
            o_err_inj_cnt <= o_err_inj_cnt + 16'd1;
        end else if (i_err_inj) begin
            inj_pend      <= 1'b1;
        end
    end
`else
    assign word = pat_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_r     <= 1'b0;
            len_r       <= LEN_W'(LEN_NORM);
            frame_num_r <= 16'd0;
            gap_r       <= 16'd0;
            gap_cnt     <= 16'd0;
            stop_pend   <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= 64'h0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= 16'd0;
            o_done      <= 1'b0;
        end else if (i_soft_rst) begin
            state       <= IDLE;
            start_r     <= 1'b0;
            len_r       <= LEN_W'(LEN_NORM);
            frame_num_r <= 16'd0;
            gap_r       <= 16'd0;
            gap_cnt     <= 16'd0;
            stop_pend   <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= 64'h0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= 16'd0;
            o_done      <= 1'b0;
        end else begin
            start_r <= i_tx_start;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (start_p) begin
                        state       <= DATA;
                        len_r       <= (i_tx_mode == MODE_LONG) ? LEN_W'(LEN_LONG) : LEN_W'(LEN_NORM);
                        frame_num_r <= i_frame_num;
                        gap_r       <= i_gap_cycles;
                        o_frame_cnt <= 16'd0;
                        o_busy      <= 1'b1;
                    end
                end
                DATA: begin
                    if (i_tx_stop) stop_pend <= 1'b1;
                    if (issue) begin
                        o_valid <= 1'b1;
                        o_data  <= word;
                        o_sof   <= pat_first;
                        o_eof   <= pat_last;
                        if (pat_last) begin
                            o_frame_cnt <= o_frame_cnt + 16'd1;
                            if (target_met || stop_now) begin
                                state <= DONE;
                            end else if (gap_r != 16'd0) begin
                                state   <= GAP;
                                gap_cnt <= gap_r;
                            end
                        end
                    end
                end
                GAP: begin
                    if (stop_now) begin
                        state <= DONE;
                    end else begin
                        if (gap_cnt == 16'd1) state <= DATA;
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_frame_sched.sv
// Self-checking bench for tlk2711_tx_frame_sched: table-driven runs, randomized runs
// against a pattern model, and hand-written reset sequences.
module tb_tlk2711_tx_frame_sched;

    localparam int          LEN_N  = 435;
    localparam int          LEN_L  = 5377;
    localparam logic [15:0] P_INIT = 16'h0001;
    localparam logic [15:0] P_STEP = 16'h0202;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] frame_num;
        logic [15:0] gap;
        int          ready_mode;
        int          stop_frame;
        int          stop_word;
        bit          busy_start;
        int          exp_words;
        int          exp_frames;
        int          exp_done_delay;
        logic [15:0] exp_last_pat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_soft_rst;
    logic        i_tx_start;
    logic [2:0]  i_tx_mode;
    logic [15:0] i_frame_num;
    logic [15:0] i_gap_cycles;
    logic        i_tx_stop;
    logic        i_fifo_ready;
    logic        o_valid;
    logic [63:0] o_data;
    logic        o_sof;
    logic        o_eof;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic        o_done;
`ifdef TLK2711_TX_SCHED_ERRINJ_EN
    logic        i_err_inj;
    logic [15:0] o_err_inj_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    tlk2711_tx_frame_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_soft_rst   (i_soft_rst),
        .i_tx_start   (i_tx_start),
        .i_tx_mode    (i_tx_mode),
        .i_frame_num  (i_frame_num),
        .i_gap_cycles (i_gap_cycles),
        .i_tx_stop    (i_tx_stop),
        .i_fifo_ready (i_fifo_ready),
`ifdef TLK2711_TX_SCHED_ERRINJ_EN
        .i_err_inj    (i_err_inj),
        .o_err_inj_cnt(o_err_inj_cnt),
`endif
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_sof        (o_sof),
        .o_eof        (o_eof),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Word w of a frame of length L: pattern INIT + w*STEP mod 2^16 on all lanes, filler last.
    function automatic logic [63:0] exp_word(input int w, input int len);
        int          t;
        logic [15:0] p;
        if (w == len - 1) return 64'h0;
        t = int'(P_INIT) + w * int'(P_STEP);
        p = t[15:0];
        return {4{p}};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_tx_mode    = v.mode;
        i_frame_num  = v.frame_num;
        i_gap_cycles = v.gap;
        i_tx_stop    = 1'b0;
        i_fifo_ready = (v.ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        i_tx_start   = 1'b1;
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int          len, w, words, frames, samples, last_eof, done_cnt, done_at, post;
        int          err, gap_err, budget;
        bit          ready_seen, busy_at_done, finished, stop_fire;
        logic [15:0] cnt_at_done, last_pat;
        logic [63:0] exp_d;
        len = (v.mode == 3'd3) ? LEN_L : LEN_N;
        w = 0; words = 0; frames = 0; samples = 0; last_eof = 0;
        done_cnt = 0; done_at = 0; post = 0; err = 0; gap_err = 0;
        busy_at_done = 1'b1; finished = 1'b0; cnt_at_done = 16'hFFFF; last_pat = 16'h0;
        budget = v.exp_words * 4 + 200;
        @(negedge clk);
        applyStimulus(v);
        while (!finished && samples < budget) begin
            ready_seen = i_fifo_ready;
            @(posedge clk);
            @(negedge clk);
            samples++;
            stop_fire = 1'b0;
            if (o_valid) begin
                if (!ready_seen || done_cnt > 0 || !o_busy) err++;
                exp_d = exp_word(w, len);
                if (o_data !== exp_d || o_sof !== (w == 0) || o_eof !== (w == len - 1)) begin
                    if (err == 0)
                        $display("[TB] %s word %0d of frame %0d: data %h sof %b eof %b",
                                 tag, w, frames + 1, o_data, o_sof, o_eof);
                    err++;
                end
                if (w == 0 && frames > 0 && v.ready_mode == 0 && (samples - last_eof - 1) != int'(v.gap))
                    gap_err++;
                if (frames + 1 == v.stop_frame && w == v.stop_word) stop_fire = 1'b1;
                if (w == len - 2) last_pat = o_data[15:0];
                words++;
                if (w == len - 1) begin
                    frames++;
                    last_eof = samples;
                    if (o_frame_cnt !== 16'(frames)) err++;
                    w = 0;
                end else begin
                    w++;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_at      = samples;
                busy_at_done = o_busy;
                cnt_at_done  = o_frame_cnt;
            end
            if (samples == 3) begin
                i_tx_start   = 1'b0;
                i_tx_mode    = (v.mode == 3'd3) ? 3'd0 : 3'd3;
                i_frame_num  = v.frame_num + 16'd5;
                i_gap_cycles = v.gap + 16'd7;
            end
            if (v.busy_start && words == 10) i_tx_start = 1'b1;
            if (v.busy_start && words == 20) i_tx_start = 1'b0;
            i_tx_stop = stop_fire;
            case (v.ready_mode)
                1:       i_fifo_ready = ~i_fifo_ready;
                2:       i_fifo_ready = ($urandom_range(0, 3) != 0);
                default: i_fifo_ready = 1'b1;
            endcase
            if (done_cnt > 0) post++;
            if (post >= 4) finished = 1'b1;
        end
        i_tx_stop = 1'b0;
        checkOutput({tag, "_finished"}, 64'(finished), 64'd1);
        checkOutput({tag, "_words"}, 64'(words), 64'(v.exp_words));
        checkOutput({tag, "_frames"}, 64'(frames), 64'(v.exp_frames));
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, "_done_delay"}, 64'(done_at - last_eof), 64'(v.exp_done_delay));
        checkOutput({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        checkOutput({tag, "_frame_cnt"}, 64'(cnt_at_done), 64'(v.exp_frames));
        checkOutput({tag, "_word_errors"}, 64'(err), 64'd0);
        checkOutput({tag, "_gap_errors"}, 64'(gap_err), 64'd0);
        checkOutput({tag, "_last_pattern"}, 64'(last_pat), 64'(v.exp_last_pat));
    endtask

    task automatic reset_sequences();
        int lat, words, dones;
        bit got;
        @(negedge clk);
        i_tx_mode = 3'd0; i_frame_num = 16'd1; i_gap_cycles = 16'd0;
        i_fifo_ready = 1'b1; i_tx_start = 1'b1;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (o_valid) got = 1'b1;
        end
        checkOutput("first_valid_latency", 64'(lat), 64'd2);
        words = got ? 1 : 0;
        for (int c = 0; c < 200 && words < 51; c++) begin
            @(posedge clk); @(negedge clk);
            if (o_valid) words++;
        end
        checkOutput("reached_word50", 64'(words), 64'd51);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(o_valid), 64'd0);
        checkOutput("async_rst_busy", 64'(o_busy), 64'd0);
        i_tx_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (o_done || o_valid) dones++;
        end
        checkOutput("no_done_after_rst", 64'(dones), 64'd0);
        i_tx_start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); @(negedge clk);
            if (o_valid) got = 1'b1;
        end
        checkOutput("restart_sof", 64'({got, o_sof}), 64'b11);
        checkOutput("restart_data", o_data, 64'h0001_0001_0001_0001);
        i_tx_start = 1'b0;
        i_soft_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("soft_rst_valid_busy", 64'({o_valid, o_busy}), 64'd0);
        i_soft_rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t rv;
        logic [63:0] lp;
        tbl[0] = '{3'd0, 16'd2, 16'd4, 0, 0, 0,   1'b0, 870,  2, 1, 16'h6563};
        tbl[1] = '{3'd3, 16'd1, 16'd0, 0, 0, 0,   1'b0, 5377, 1, 1, 16'h27FF};
        tbl[2] = '{3'd0, 16'd1, 16'd0, 1, 0, 0,   1'b0, 435,  1, 1, 16'h6563};
        tbl[3] = '{3'd5, 16'd0, 16'd0, 0, 3, 100, 1'b0, 1305, 3, 1, 16'h6563};
        tbl[4] = '{3'd2, 16'd3, 16'd0, 0, 0, 0,   1'b0, 1305, 3, 1, 16'h6563};
        tbl[5] = '{3'd7, 16'd1, 16'd2, 0, 0, 0,   1'b1, 435,  1, 1, 16'h6563};
        tbl[6] = '{3'd0, 16'd0, 16'd3, 0, 2, 433, 1'b0, 870,  2, 1, 16'h6563};
        tbl[7] = '{3'd1, 16'd0, 16'd8, 0, 1, 434, 1'b0, 435,  1, 2, 16'h6563};

        rst_n = 1'b0; i_soft_rst = 1'b0; i_tx_start = 1'b0; i_tx_mode = 3'd0;
        i_frame_num = 16'd0; i_gap_cycles = 16'd0; i_tx_stop = 1'b0; i_fifo_ready = 1'b1;
`ifdef TLK2711_TX_SCHED_ERRINJ_EN
        i_err_inj = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {o_valid, o_sof, o_eof, o_busy, o_done, o_frame_cnt[10:0], o_data[47:0]}, 64'd0);
        checkOutput("reset_data", o_data, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        reset_sequences();

        for (int i = 0; i < 8; i++) run_case(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            rv.mode = 3'($urandom_range(0, 7));
            if (rv.mode == 3'd3) rv.mode = 3'd6;
            rv.frame_num      = 16'($urandom_range(1, 3));
            rv.gap            = 16'($urandom_range(0, 5));
            rv.ready_mode     = 2;
            rv.stop_frame     = 0;
            rv.stop_word      = 0;
            rv.busy_start     = 1'b0;
            rv.exp_words      = int'(rv.frame_num) * LEN_N;
            rv.exp_frames     = int'(rv.frame_num);
            rv.exp_done_delay = 1;
            lp                = exp_word(LEN_N - 2, LEN_N);
            rv.exp_last_pat   = lp[15:0];
            run_case(rv, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
